// File: rtl/uart_pkg.sv
// Shared definitions for the UART-side blocks (transmit arbiter, string
// sender, DHT11 reader): arbiter state encoding, requester identifiers,
// default stall limit and the arbitration helper.
package uart_pkg;

    // 10 ms at 100 MHz: how long a half-sent message may stall before it is dropped.
    localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

    // Cycles WAIT_HI waits for tx_busy to rise before moving on regardless.
    localparam int WAIT_HI_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } arb_state_t;

    // s0 carries command acknowledgements, s1 carries telemetry.
    typedef enum logic {
        SRC_S0 = 1'b0,
        SRC_S1 = 1'b1
    } src_t;

    // One-hot grant pattern for a requester.
    function automatic logic [1:0] src_onehot(input src_t src);
        logic [1:0] oh;
        if (src == SRC_S1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

    // Picks the next owner: a lone requester wins outright, under contention
    // the requester that was not served last wins.
    function automatic src_t pick_src(input logic v0, input logic v1, input src_t last_served);
        src_t win;
        if (v0 && v1) begin
            if (last_served == SRC_S1) begin
                win = SRC_S0;
            end else begin
                win = SRC_S1;
            end
        end else if (v1) begin
            win = SRC_S1;
        end else begin
            win = SRC_S0;
        end
        return win;
    endfunction

endpackage

// File: rtl/stall_timer.sv
// Saturating stall counter. Counts enabled cycles since the last clear and
// flags expiry once LIMIT cycles have been counted; it never wraps.
module stall_timer
    import uart_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count;

    // Clear wins over enable; counting stops at the limit instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT_C)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT_C);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of the UART byte transmitter. A granted
// requester keeps the transmitter for a whole message; bytes are fetched one
// at a time, started with a single-cycle tx_start, and the arbiter waits for
// the transmitter's busy pulse to finish before fetching the next byte.
// A message that stalls mid-way for TIMEOUT_CYCLES is abandoned with abort.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk_100Mhz,
    input  logic       rst,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       abort,
    output arb_state_t state_dbg
);

    // Handshake: a requester holds valid (with data/last stable) until it
    // samples ready high on a rising edge; the byte transfers on exactly the
    // edge where valid and ready are both high. ready is only ever offered to
    // the current owner, in FETCH, while the transmitter is idle, and never
    // depends on the requester's own valid.

    localparam logic [1:0] WAIT_HI_LAST = 2'(WAIT_HI_CYCLES - 1);

    arb_state_t state_q, state_d;
    src_t       owner_q, owner_d;
    logic       active_q, active_d;
    src_t       last_served_q, last_served_d;
    logic [7:0] data_q, data_d;
    logic       last_q, last_d;
    logic       first_done_q, first_done_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;

    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       ready_int;
    logic       timer_clear;
    logic       timer_en;
    logic       timer_expired;

    // Route the owner's request signals to a single set used by the FSM.
    always_comb begin
        sel_valid = s0_valid;
        sel_data  = s0_data;
        sel_last  = s0_last;
        if (owner_q == SRC_S1) begin
            sel_valid = s1_valid;
            sel_data  = s1_data;
            sel_last  = s1_last;
        end
    end

    // State and message context registers; reset drops any latched byte.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= SRC_S0;
            active_q      <= 1'b0;
            last_served_q <= SRC_S1;
            data_q        <= 8'h00;
            last_q        <= 1'b0;
            first_done_q  <= 1'b0;
            wait_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            active_q      <= active_d;
            last_served_q <= last_served_d;
            data_q        <= data_d;
            last_q        <= last_d;
            first_done_q  <= first_done_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Next-state logic and per-cycle strobes for the arbiter FSM.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        active_d      = active_q;
        last_served_d = last_served_q;
        data_d        = data_q;
        last_d        = last_q;
        first_done_d  = first_done_q;
        wait_cnt_d    = wait_cnt_q;
        ready_int     = 1'b0;
        tx_start      = 1'b0;
        abort         = 1'b0;
        timer_clear   = 1'b0;
        timer_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Keep the timer from carrying a stale count into a new message.
                timer_clear = 1'b1;
                if (s0_valid || s1_valid) begin
                    owner_d      = pick_src(s0_valid, s1_valid, last_served_q);
                    active_d     = 1'b1;
                    first_done_d = 1'b0;
                    state_d      = ST_FETCH;
                end
            end

            ST_FETCH: begin
                ready_int = !tx_busy;
                if (sel_valid && !tx_busy) begin
                    data_d       = sel_data;
                    last_d       = sel_last;
                    first_done_d = 1'b1;
                    timer_clear  = 1'b1;
                    state_d      = ST_START;
                end else if (!first_done_q) begin
                    // Requester withdrew before sending anything: nothing to abandon.
                    if (!sel_valid) begin
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end else if (timer_expired) begin
                    abort         = 1'b1;
                    active_d      = 1'b0;
                    last_served_d = owner_q;
                    state_d       = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end

            ST_START: begin
                tx_start   = 1'b1;
                wait_cnt_d = 2'd0;
                state_d    = ST_WAIT_HI;
            end

            ST_WAIT_HI: begin
                // Fall through after a short wait so a missed busy pulse cannot hang us.
                if (tx_busy || (wait_cnt_q == WAIT_HI_LAST)) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        active_d      = 1'b0;
                        last_served_d = owner_q;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    stall_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk     (clk_100Mhz),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    assign s0_ready  = ready_int && (owner_q == SRC_S0);
    assign s1_ready  = ready_int && (owner_q == SRC_S1);
    assign tx_data   = data_q;
    assign grant     = active_q ? src_onehot(owner_q) : 2'b00;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of message scenarios checked through an
// expected-byte scoreboard, plus hand sequences for timeout, transmitter
// stall and mid-message reset. A small transmitter model drives tx_busy.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int TIMEOUT = 50;
    localparam int GUARD   = 2000;
    localparam int NV      = 5;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       s0_valid = 1'b0, s1_valid = 1'b0;
    logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
    logic       s0_last = 1'b0, s1_last = 1'b0;
    logic       s0_ready, s1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic [1:0] grant;
    logic       abort;
    arb_state_t state_dbg;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_100Mhz (clk),
        .rst        (rst),
        .s0_valid   (s0_valid),
        .s0_data    (s0_data),
        .s0_last    (s0_last),
        .s0_ready   (s0_ready),
        .s1_valid   (s1_valid),
        .s1_data    (s1_data),
        .s1_last    (s1_last),
        .s1_ready   (s1_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant      (grant),
        .abort      (abort),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];   // {grant, tx_data} expected at each tx_start

    int cyc = 0, start_cnt = 0, abort_cnt = 0, abort_lat = -1, busy_fall_cyc = 0;
    int viol = 0, lat_viol = 0;
    bit prev_busy = 0, prev_start = 0, abort_prev = 0, stab_en = 0;
    bit lat_en = 0, lat_armed = 0, src_abort = 0, force_busy = 0;
    logic [1:0] grant_after_abort = 2'b11;
    logic [7:0] cur_data = 8'h00;
    int pend = 0, busy_left = 0, next_len = 4;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- transmitter model ----------------
    // Busy rises 1-2 cycles after tx_start and stays high for a random length.
    always @(posedge clk) begin
        #1;
        if (pend > 0) begin
            pend--;
            if (pend == 0) busy_left = next_len;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        tx_busy = force_busy || (busy_left > 0);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [9:0] e;
        cyc++;
        if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
        prev_busy = tx_busy;
        if (rst) begin
            prev_start = 0;
            stab_en    = 0;
            abort_prev = 0;
        end else begin
            if (s0_ready && grant != 2'b01) viol++;
            if (s1_ready && grant != 2'b10) viol++;
            if (tx_start && prev_start) viol++;
            prev_start = tx_start;
            if (stab_en && tx_busy && tx_data !== cur_data) viol++;
            if (abort_prev) grant_after_abort = grant;
            abort_prev = abort;
            if (abort) begin
                abort_cnt++;
                abort_lat = cyc - busy_fall_cyc;
            end
            if (tx_start) begin
                start_cnt++;
                pend     = $urandom_range(1, 2);
                next_len = $urandom_range(3, 8);
                cur_data = tx_data;
                stab_en  = 1;
                if (lat_en && lat_armed && (cyc - busy_fall_cyc > 3)) lat_viol++;
                lat_armed = (tx_data != 8'h0A);
                check("tx_start_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tx_grant_data", {grant, tx_data}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_src(input int idx, input logic v, input logic [7:0] d, input logic l);
        if (idx == 0) begin
            s0_valid = v; s0_data = d; s0_last = l;
        end else begin
            s1_valid = v; s1_data = d; s1_last = l;
        end
    endtask

    function automatic logic src_ready(input int idx);
        return (idx == 0) ? s0_ready : s1_ready;
    endfunction

    // Sends msg byte by byte; last is flagged on '\n'. Optional gaps only
    // occur inside a message so arbitration order stays deterministic.
    task automatic run_source(input int idx, input string msg, input bit gaps);
        for (int i = 0; i < msg.len(); i++) begin
            int guard;
            logic [7:0] b;
            logic [7:0] pb;
            guard = 0;
            b = msg[i];
            pb = (i > 0) ? msg[i-1] : 8'h0A;
            if (gaps && pb != 8'h0A) begin
                drive_src(idx, 1'b0, 8'h00, 1'b0);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            drive_src(idx, 1'b1, b, (b == 8'h0A));
            do begin
                @(negedge clk);
                guard++;
            end while (!src_ready(idx) && !src_abort && guard < GUARD);
            if (src_abort) begin
                drive_src(idx, 1'b0, 8'h00, 1'b0);
                return;
            end
            if (guard >= GUARD) begin
                n_tests++; n_fail++;
                $display("FAIL src%0d_handshake: no ready after %0d cycles, required ready", idx, guard);
                drive_src(idx, 1'b0, 8'h00, 1'b0);
                return;
            end
            @(posedge clk);
            #1;
        end
        drive_src(idx, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive_src(0, 1'b0, 8'h00, 1'b0);
        drive_src(1, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {grant, s0_ready, s1_ready, tx_start, tx_data, abort}, 32'h0);
        check("reset_state", state_dbg, ST_IDLE);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(exp_q.size() == 0 && grant == 2'b00 && state_dbg == ST_IDLE) && g < GUARD);
        n_tests++;
        if (g >= GUARD) begin
            n_fail++;
            $display("FAIL %s_drain: %0d bytes still expected, grant=%b, required 0 bytes and idle", name, exp_q.size(), grant);
        end
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        string name;
        string s0;
        string s1;
        string exp_b;
        string exp_g;   // per expected byte: "1" -> grant 01, "2" -> grant 10
        bit    gaps;
        bit    lat;
    } vec_t;

    function automatic vec_t mk(input string n, input string a, input string b,
                                input string eb, input string eg, input bit gp, input bit lt);
        vec_t r;
        r.name = n; r.s0 = a; r.s1 = b; r.exp_b = eb; r.exp_g = eg; r.gaps = gp; r.lat = lt;
        return r;
    endfunction

    function automatic logic [1:0] grant_of(input logic [7:0] c);
        return (c == "2") ? 2'b10 : 2'b01;
    endfunction

    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string eb, eg;
        int s, g;

        vecs[0] = mk("s1_alone",    "",          "T:25\n",   "T:25\n",             "22222",        1'b0, 1'b1);
        vecs[1] = mk("contend",     "OK\n",      "H:60\n",   "OK\nH:60\n",         "11122222",     1'b0, 1'b0);
        vecs[2] = mk("alternate",   "A1\nA2\n",  "B1\nB2\n", "A1\nB1\nA2\nB2\n",   "111222111222", 1'b0, 1'b0);
        vecs[3] = mk("s0_gaps",     "OK\n",      "",         "OK\n",               "111",          1'b1, 1'b0);
        vecs[4] = mk("mixed_gaps",  "X\nYZ\n",   "T:25\n",   "X\nT:25\nYZ\n",      "1122222111",   1'b1, 1'b0);

        repeat (3) @(posedge clk);

        for (int v = 0; v < NV; v++) begin
            do_reset();
            viol = 0; lat_viol = 0; abort_cnt = 0; lat_armed = 0;
            lat_en = vecs[v].lat;
            eb = vecs[v].exp_b;
            eg = vecs[v].exp_g;
            for (int k = 0; k < eb.len(); k++) exp_q.push_back({grant_of(eg[k]), 8'(eb[k])});
            fork
                run_source(0, vecs[v].s0, vecs[v].gaps);
                run_source(1, vecs[v].s1, vecs[v].gaps);
            join
            wait_drain(vecs[v].name);
            check({vecs[v].name, "_protocol"}, viol, 0);
            check({vecs[v].name, "_no_abort"}, abort_cnt, 0);
            if (lat_en) check({vecs[v].name, "_byte_latency"}, lat_viol, 0);
            lat_en = 0;
        end

        // Timeout: s0 sends 'L' without last and goes quiet while s1 waits.
        do_reset();
        viol = 0; abort_cnt = 0; abort_lat = -1; grant_after_abort = 2'b11;
        exp_q.push_back({2'b01, 8'h4C});
        exp_q.push_back({2'b10, 8'h5A});
        exp_q.push_back({2'b10, 8'h0A});
        fork
            run_source(0, "L", 1'b0);
            run_source(1, "Z\n", 1'b0);
        join
        wait_drain("timeout");
        check("timeout_abort_count", abort_cnt, 1);
        // busy falls, one cycle to return to FETCH, then TIMEOUT counted cycles
        check("timeout_abort_delay", abort_lat, TIMEOUT + 1);
        check("timeout_grant_cleared", grant_after_abort, 2'b00);
        check("timeout_protocol", viol, 0);

        // Transmitter held busy: a new message must wait without handshaking.
        do_reset();
        viol = 0; abort_cnt = 0;
        exp_q.push_back({2'b10, 8'h54});
        exp_q.push_back({2'b10, 8'h0A});
        run_source(1, "T\n", 1'b0);
        wait_drain("pre_stall");
        force_busy = 1;
        @(posedge clk); #2;
        exp_q.push_back({2'b01, 8'h4F});
        exp_q.push_back({2'b01, 8'h4B});
        exp_q.push_back({2'b01, 8'h0A});
        s = start_cnt;
        fork
            run_source(0, "OK\n", 1'b0);
            begin
                int rdy_hits, data_bad;
                rdy_hits = 0; data_bad = 0;
                repeat (1000) begin
                    @(negedge clk);
                    if (s0_ready || s1_ready) rdy_hits++;
                    if (tx_data !== 8'h0A) data_bad++;
                end
                #1;
                check("stall_no_tx_start", start_cnt - s, 0);
                check("stall_ready_low", rdy_hits, 0);
                check("stall_tx_data_stable", data_bad, 0);
                check("stall_grant_held", grant, 2'b01);
                check("stall_no_abort", abort_cnt, 0);
                force_busy = 0;
            end
        join
        wait_drain("stall");
        check("stall_protocol", viol, 0);

        // Reset after the second byte of a message.
        do_reset();
        exp_q.push_back({2'b10, 8'h54});
        exp_q.push_back({2'b10, 8'h3A});
        s = start_cnt;
        fork
            run_source(1, "T:25\n", 1'b0);
            begin
                g = 0;
                do begin
                    @(negedge clk); #1;
                    g++;
                end while ((start_cnt - s) < 2 && g < GUARD);
                check("rst_seq_two_bytes", start_cnt - s, 2);
                @(posedge clk); #1;
                rst = 1'b1;
                src_abort = 1;
                @(posedge clk);
                @(negedge clk);
                check("rst_mid_outputs", {grant, s0_ready, s1_ready, tx_start, tx_data, abort}, 32'h0);
                check("rst_mid_state", state_dbg, ST_IDLE);
                @(posedge clk); #1;
                rst = 1'b0;
                s = start_cnt;
                repeat (200) @(negedge clk);
                #1;
                check("rst_no_more_start", start_cnt - s, 0);
                check("rst_queue_empty", exp_q.size(), 0);
            end
        join
        src_abort = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000: mid-message stall limit in clock cycles (10 ms at 100 MHz).
REQ-002 SHALL have port clk_100Mhz  input  1  system clock; one clock, all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports s0_valid/s1_valid  input  1 each  requester byte valid (s0 = command ack, s1 = telemetry).
REQ-005 SHALL have ports s0_data/s1_data  input  8 each  requester byte.
REQ-006 SHALL have ports s0_last/s1_last  input  1 each  byte is the final byte of the message.
REQ-007 SHALL have ports s0_ready/s1_ready  output  1 each  byte accepted when valid and ready are both high.
REQ-008 SHALL have port tx_start  output  1  single-cycle pulse to the UART byte transmitter.
REQ-009 SHALL have port tx_data  output  8  byte for the transmitter; stable from the tx_start cycle until tx_busy falls.
REQ-010 SHALL have port tx_busy  input  1  transmitter busy; rises within 2 cycles of tx_start.
REQ-011 SHALL have port grant  output  2  one-hot owner of the transmitter; 2'b00 when idle.
REQ-012 SHALL have port abort  output  1  single-cycle pulse when a message is abandoned on timeout.

Function
REQ-013 SHALL implement states IDLE, FETCH, START, WAIT_HI, WAIT_LO.
REQ-014 IDLE: no valid -> stay; one valid -> grant that requester; both valid -> grant the requester not served last; go to FETCH.
REQ-015 SHALL lock the grant for a whole message, with no interleaving of bytes from different requesters.
REQ-016 FETCH: ready is high for the granted requester only, and only when tx_busy is low; on handshake, latch data and last, clear the timeout counter, go to START.
REQ-017 START: assert tx_start for exactly one cycle, go to WAIT_HI.
REQ-018 WAIT_HI: on tx_busy high -> WAIT_LO; if tx_busy stays low for 2 cycles -> WAIT_LO anyway.
REQ-019 WAIT_LO: on tx_busy low, if latched last -> clear grant, set last-served to this requester, go to IDLE; else go to FETCH.
REQ-020 Byte-to-byte latency SHALL be no more than 3 cycles beyond tx_busy falling when the source holds valid.
REQ-021 Timeout counter SHALL count only in FETCH after the first byte of a message; at TIMEOUT_CYCLES -> abort pulse, clear grant, set last-served to the aborting requester, go to IDLE.
REQ-022 Valid deasserting in FETCH before the first byte SHALL return to IDLE without abort.
REQ-023 The non-granted requester's ready SHALL stay low.
REQ-024 A request arriving in the same cycle a message completes SHALL be arbitrated in the next IDLE cycle.
REQ-025 Counter width SHALL be clog2(TIMEOUT_CYCLES+1) with no wrap-around; it saturates at the limit.

Reset
REQ-026 On rst, state SHALL be IDLE, grant=0, s0_ready=s1_ready=0, tx_start=0, tx_data=0, abort=0, counter=0.
REQ-027 On rst, last-served SHALL be s1, so s0 wins the first contention.
REQ-028 Reset mid-message SHALL discard the latched byte with no further tx_start; a byte already in the transmitter is not recalled.

Structure
REQ-029 State encoding and the default TIMEOUT_CYCLES SHALL live in shared package uart_pkg, reused by the UART string and DHT11 blocks.
REQ-030 Timeout counter SHALL be sub-module stall_timer (clear, enable, expired).
REQ-031 The arbiter SHALL contain no baud logic and SHALL drive the existing UART byte transmitter.

Verification
REQ-032 Bench SHALL cover: s1 sends "T:25\n" alone -> 5 tx_start pulses with tx_data 0x54,0x3A,0x32,0x35,0x0A; grant=2'b10 throughout; then grant=2'b00.
REQ-033 Bench SHALL cover: s0 "OK\n" and s1 "H:60\n" valid in the same cycle after reset -> 0x4F,0x4B,0x0A, then 0x48,0x3A,0x36,0x30,0x0A.
REQ-034 Bench SHALL cover: s0 and s1 request back-to-back continuously -> grants alternate 01,10,01,10 at message boundaries.
REQ-035 Bench SHALL cover: TIMEOUT_CYCLES=50, s0 sends 0x4C with last=0 then drops valid -> abort pulse 50 cycles later, grant=0, pending s1 then granted.
REQ-036 Bench SHALL cover: tx_busy held high 1000 cycles -> granted ready stays low, no extra tx_start, tx_data stable.
REQ-037 Bench SHALL cover: rst asserted after the 2nd byte of "T:25\n" -> all outputs at reset values next cycle, no further tx_start.
